// File: rtl/sine_pkg.sv
// Shared constants and FSM state type for the sine phase recovery path.
package sine_pkg;

    localparam int unsigned AMPLITUDE = 716;
    localparam int unsigned N_SAMPLES = 2048;
    localparam int unsigned QUARTER   = 512;
    localparam int unsigned HYST      = 2;
    localparam int unsigned PHASE_W   = 11;
    localparam int unsigned SAMPLE_W  = 11;
    localparam int unsigned ADDR_W    = 10;
    localparam int unsigned ROM_W     = 10;
    localparam int unsigned BIT_W     = 4;

    typedef enum logic [1:0] {
        IDLE,
        RD,
        CMP,
        OUT
    } state_t;

endpackage

// File: rtl/sine_quarter_rom.sv
// Quarter-wave sine ROM, QUARTER+1 entries of trunc(AMPLITUDE*sin(2*pi*k/N_SAMPLES)).
// Synchronous read with one cycle of latency; addresses above QUARTER read as zero.
module sine_quarter_rom
    import sine_pkg::*;
(
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    output logic [ROM_W-1:0]  data
);

    localparam real PI = 3.141592653589793;

    logic [ROM_W-1:0] tbl [0:QUARTER];

    // Contents are constant-folded at elaboration.
    for (genvar i = 0; i <= QUARTER; i++) begin : g_tbl
        localparam int VAL = $rtoi(AMPLITUDE * $sin(2.0 * PI * i / N_SAMPLES));
        assign tbl[i] = ROM_W'(VAL);
    end

    always_ff @(posedge clk) begin
        if (addr <= ADDR_W'(QUARTER)) begin
            data <= tbl[addr];
        end else begin
            data <= '0;
        end
    end

endmodule

// File: rtl/sine_phase_recover.sv
// Recovers the 11-bit sawtooth phase from a signed sine sample via a SAR search
// over the quarter-wave ROM. Optional slope deadband: define SINE_PHASE_HYST_EN.
module sine_phase_recover
    import sine_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic signed [SAMPLE_W-1:0] sample_in,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [PHASE_W-1:0]         phase_out,
    output logic                       out_valid
);

    localparam int unsigned ACC_W = PHASE_W + 1;
    localparam int unsigned EXT_W = SAMPLE_W + 1;

    state_t state, next_state;

    logic signed [SAMPLE_W-1:0] x_prev;
    logic                       x_neg;
    logic                       rising;
    logic [ROM_W-1:0]           a;
    logic [ADDR_W-1:0]          k;
    logic [BIT_W-1:0]           bit_idx;

    logic                       accept;
    logic [ADDR_W-1:0]          cand;
    logic                       cand_ok;
    logic [ROM_W-1:0]           rom_data;
    logic [EXT_W-1:0]           x_ext;
    logic [EXT_W-1:0]           mag;
    logic [ROM_W-1:0]           a_next;
    logic                       rising_next;
    logic [ACC_W-1:0]           phase_next;

    sine_quarter_rom u_rom (
        .clk  (clk),
        .addr (cand),
        .data (rom_data)
    );

    assign accept  = in_valid & in_ready;
    assign cand    = k | (ADDR_W'(1) << bit_idx);
    assign cand_ok = (cand <= ADDR_W'(QUARTER)) && (rom_data <= a);

    // Magnitude with -1024 widened to 1024, then clamped to the table peak.
    assign x_ext  = {sample_in[SAMPLE_W-1], sample_in};
    assign mag    = sample_in[SAMPLE_W-1] ? (-x_ext) : x_ext;
    assign a_next = (mag > EXT_W'(AMPLITUDE)) ? ROM_W'(AMPLITUDE) : mag[ROM_W-1:0];

`ifdef SINE_PHASE_HYST_EN
    logic signed [EXT_W-1:0] diff;
    logic        [EXT_W-1:0] diff_mag;

    assign diff        = $signed({sample_in[SAMPLE_W-1], sample_in}) - $signed({x_prev[SAMPLE_W-1], x_prev});
    assign diff_mag    = diff[EXT_W-1] ? EXT_W'(-diff) : EXT_W'(diff);
    assign rising_next = (diff_mag > EXT_W'(HYST)) ? ~diff[EXT_W-1] : rising;
`else
    assign rising_next = (sample_in >= x_prev);
`endif

    // Quadrant unfolding from sign and slope.
    always_comb begin
        phase_next = '0;
        case ({x_neg, rising})
            2'b01:   phase_next = ACC_W'(k);
            2'b00:   phase_next = ACC_W'(N_SAMPLES / 2) - ACC_W'(k);
            2'b10:   phase_next = ACC_W'(N_SAMPLES / 2) + ACC_W'(k);
            default: phase_next = ACC_W'(N_SAMPLES) - ACC_W'(k);
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = RD;
            RD:      next_state = CMP;
            CMP:     next_state = (bit_idx == '0) ? OUT : RD;
            OUT:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            phase_out <= '0;
            x_prev    <= '0;
            x_neg     <= 1'b0;
            rising    <= 1'b1;
            a         <= '0;
            k         <= '0;
            bit_idx   <= '0;
        end else begin
            in_ready  <= (next_state == IDLE);
            out_valid <= (state == OUT);
            if (state == OUT) begin
                phase_out <= PHASE_W'(phase_next);
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        x_neg   <= sample_in[SAMPLE_W-1];
                        a       <= a_next;
                        rising  <= rising_next;
                        x_prev  <= sample_in;
                        k       <= '0;
                        bit_idx <= BIT_W'(ADDR_W - 1);
                    end
                end
                CMP: begin
                    if (cand_ok) begin
                        k <= cand;
                    end
                    if (bit_idx != '0) begin
                        bit_idx <= bit_idx - BIT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sine_phase_recover.sv
// Directed bench for sine_phase_recover: reset, quadrant table, clamping, busy
// behaviour, mid-search reset, peak deadband and a full-period loopback sweep.
module tb_sine_phase_recover;

    localparam real PI = 3.141592653589793;

    logic               clk = 1'b0;
    logic               rst;
    logic signed [10:0] sample_in;
    logic               in_valid;
    logic               in_ready;
    logic [10:0]        phase_out;
    logic               out_valid;

    int n_checks = 0;
    int n_fail   = 0;

    int q_tb [0:512];
    int seq_x   [7] = '{506, 716, 506, -506, -716, -506, 0};
    int seq_exp [7] = '{256, 512, 768, 1280, 1536, 1792, 0};
    int peak_x  [3] = '{715, 716, 715};
    int peak_exp [3];
    int got_ph  [3];
    int m_prev;
    bit m_rising;

    sine_phase_recover dut (
        .clk       (clk),
        .rst       (rst),
        .sample_in (sample_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .phase_out (phase_out),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Called #1 after a rising edge; returns the phase and accept-to-out_valid latency.
    task automatic send(input int x, output int phase, output int lat);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) check("ready_timeout", 0, 1);
        sample_in = 11'(x);
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (!out_valid) check("out_timeout", 0, 1);
        lat   = n;
        phase = int'(phase_out);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int ph, lat, n_out, x, a, k, p, prev_x, r, j, d;

        for (int i = 0; i <= 512; i++) begin
            q_tb[i] = $rtoi(716.0 * $sin(2.0 * PI * i / 2048.0));
        end
`ifdef SINE_PHASE_HYST_EN
        peak_exp = '{511, 512, 511};
`else
        peak_exp = '{511, 512, 513};
`endif

        rst = 1'b1; in_valid = 1'b0; sample_in = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        check("rst_phase", int'(phase_out), 0);
        check("rst_valid", int'(out_valid), 0);
        check("rst_ready", int'(in_ready), 1);

        send(0, ph, lat);
        check("lat_first", lat, 21);
        check("phase_zero", ph, 0);

        for (int i = 0; i < 7; i++) begin
            send(seq_x[i], ph, lat);
            check($sformatf("seq%0d", i), ph, seq_exp[i]);
        end

        send(1023, ph, lat);
        check("clamp_pos", ph, 512);
        send(-1024, ph, lat);
        check("clamp_neg", ph, 1536);

        // in_valid held high; only the samples at c = 0, 22, 44 may be consumed.
        n_out  = 0;
        got_ph = '{-1, -1, -1};
        for (int c = 0; c < 66; c++) begin
            sample_in = 11'((c == 0) ? 716 : (c == 22) ? 506 : (c == 44) ? -716 : 100 + c);
            in_valid  = 1'b1;
            @(posedge clk); #1;
            if (out_valid) begin
                if (n_out < 3) got_ph[n_out] = int'(phase_out);
                n_out++;
            end
            if (c == 5) check("busy_ready", int'(in_ready), 0);
        end
        in_valid = 1'b0;
        check("busy_count", n_out, 3);
        check("busy_ph0", got_ph[0], 512);
        check("busy_ph1", got_ph[1], 768);
        check("busy_ph2", got_ph[2], 1536);

        // Reset ten cycles into a search.
        sample_in = 11'(716);
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #2;
        check("mrst_valid", int'(out_valid), 0);
        check("mrst_phase", int'(phase_out), 0);
        check("mrst_ready", int'(in_ready), 1);
        @(posedge clk); #1 rst = 1'b0;
        n_out = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (out_valid) n_out++;
        end
        check("mrst_no_out", n_out, 0);
        send(506, ph, lat);
        check("mrst_506", ph, 256);

        for (int i = 0; i < 3; i++) begin
            send(peak_x[i], ph, lat);
            check($sformatf("peak%0d", i), ph, peak_exp[i]);
        end

        // Loopback sweep against a behavioural model.
        m_prev = 715;
`ifdef SINE_PHASE_HYST_EN
        m_rising = 1'b1;
`else
        m_rising = 1'b0;
`endif
        for (int s = 0; s < 2048; s++) begin
            x = $rtoi(716.0 * $sin(2.0 * PI * s / 2048.0));
            a = (x < 0) ? -x : x;
            if (a > 716) a = 716;
            k = 0;
            for (int i = 0; i <= 512; i++) begin
                if (q_tb[i] <= a) k = i;
            end
`ifdef SINE_PHASE_HYST_EN
            if ((x - m_prev > 2) || (m_prev - x > 2)) m_rising = (x >= m_prev);
`else
            m_rising = (x >= m_prev);
`endif
            if (x >= 0) p = m_rising ? k : 1024 - k;
            else        p = m_rising ? (2048 - k) % 2048 : 1024 + k;
            prev_x = m_prev;
            m_prev = x;

            send(x, ph, lat);
            check($sformatf("loop%0d", s), ph, p);
`ifndef SINE_PHASE_HYST_EN
            r = s % 1024;
            j = (r <= 512) ? r : 1024 - r;
            if (s > 0 && x != prev_x && j <= 384) begin
                d = (ph - s + 2048) % 2048;
                if (d > 1024) d = 2048 - d;
                check($sformatf("tol%0d", s), (d > 3) ? d : 0, 0);
            end
`endif
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sine_phase_recover.md
Name: sine_phase_recover

Overview:
- Inverse of the sine lookup path: accepts signed sine samples at the 716-amplitude / 2048-point scale and recovers the 11-bit phase (sawtooth) value.
- Magnitude is inverted by a 10-step successive-approximation search over a registered quarter-wave ROM.
- Quadrant comes from the sample sign plus slope against the previous accepted sample.
- Sits downstream of the sine generator for phase monitoring and loopback checks.

Parameters:
- AMPLITUDE, 716, peak table value; |input| is clamped to this.
- N_SAMPLES, 2048, points per period; phase width is log2(N_SAMPLES) = 11.
- QUARTER, 512, quarter-period index span; ROM holds QUARTER+1 = 513 entries.
- HYST, 2, slope deadband in LSB; used only with SINE_PHASE_HYST_EN.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- sample_in  in  11 signed  sine sample
- in_valid  in  1  sample_in is valid
- in_ready  out  1  block can accept a sample; high only in IDLE
- phase_out  out  11  recovered phase, 0..2047
- out_valid  out  1  one-cycle pulse; phase_out is new

Behaviour:
- Reset:
  - state = IDLE, in_ready = 1, phase_out = 0, out_valid = 0.
  - x_prev = 0, direction = rising.
  - Reset mid-search aborts the search and discards the result; no out_valid is produced.
- Accept: on a clk edge with in_valid & in_ready, register:
  - x = sample_in;
  - a = min(|x|, 716), where |-1024| is treated as 1024 and then clamped;
  - rising = (x >= x_prev);
  - x_prev = x, k = 0, bit = 9. Go to RD.
- in_valid while busy: ignored; no queuing.
- ROM: q[k] = trunc(716*sin(2*pi*k/2048)), k = 0..512. Read is synchronous with 1-cycle latency.
- RD: cand = k | (1<<bit); present cand as the ROM address. Next state CMP.
- CMP:
  - Accept cand only if cand <= 512 and q[cand] <= a; if accepted, k = cand.
  - Result: k = largest index in 0..512 with q[k] <= a.
  - Fixed timing: rejected-out-of-range candidates still spend their RD/CMP cycles.
  - If bit == 0, go to OUT; else decrement bit and go to RD.
- OUT, for x >= 0:
  - rising: phase_out = k
  - falling: phase_out = 1024 - k
- OUT, for x < 0:
  - falling: phase_out = 1024 + k
  - rising: phase_out = (2048 - k) mod 2048
- OUT timing: out_valid = 1 for exactly this cycle, in_ready = 0. Next state IDLE.
- phase_out holds its value until the next OUT.
- Latency: accept edge to out_valid high is 21 cycles. Throughput is one sample per 22 cycles.
- Width rules: phase arithmetic is done in 12 bits and truncated to 11 bits (mod 2048). 1024 - k with k = 512 gives 512.
- Equal consecutive samples (e.g. both at peak) count as rising.

Optional Feature:
- Macro: SINE_PHASE_HYST_EN.
- When defined:
  - The direction register updates only when |x - x_prev| > HYST; otherwise the previous direction is kept.
  - x_prev still updates on every accept.
  - Purpose: suppresses quadrant flips from noise near the peaks.
- When undefined: rising = (x >= x_prev) on every accept, and HYST is unused.

Decomposition:
- Package sine_pkg holds:
  - constants AMPLITUDE = 716, N_SAMPLES = 2048, QUARTER = 512;
  - PHASE_W = 11, SAMPLE_W = 11;
  - state enum {IDLE, RD, CMP, OUT}.
- Sub-module sine_quarter_rom:
  - 513 x 10-bit unsigned entries, block-ROM style, initial-filled;
  - registered output, addr in, data out.

Test Plan:
- After reset, no stimulus: phase_out = 0, out_valid = 0, in_ready = 1. Sample 0 -> out_valid exactly 21 cycles after accept, phase_out = 0.
- Sequence 0, 506, 716, 506, -506, -716, -506, 0 -> phases 0, 256, 512, 768, 1280, 1536, 1792, 0. Note q[256] = 506 and q[257] = 507.
- Samples 1023 and -1024 are clamped to 716 -> phase 512 after a rising history, and 1536 after a falling/negative history respectively.
- in_valid held high with changing data during a search -> only samples presented while in_ready = 1 are consumed; exactly one out_valid per accepted sample.
- rst pulsed at cycle 10 of a search -> no out_valid, all outputs 0. The next sample 506 after a reset-time x_prev of 0 -> phase 256.
- Loopback from the sine generator, saw 0..2047 step 1, one sample per 22 cycles -> |phase_out - saw| mod 2048 <= 3 wherever k <= 384, and the quadrant is never wrong. With SINE_PHASE_HYST_EN, samples 715, 716, 715 at the peak -> phase stays in Q0/Q1 with no Q3 jump.
